// File: rtl/lcd_mux_pkg.sv
// lcd_mux_pkg -- shared definitions for the multi-screen LCD scanout.
//   GB_W, GB_H, FRAME : native Game Boy LCD geometry and frame size
//   lcd_mode_e        : LCD controller mode encodings
//   sync_t            : one pixel's worth of sync/blank flags
//   h_total()         : total pixel ticks per output line
package lcd_mux_pkg;

  localparam int GB_W  = 160;
  localparam int GB_H  = 144;
  localparam int FRAME = GB_W * GB_H;

  typedef enum logic [1:0] {
    LCD_HBLANK = 2'b00,
    LCD_VBLANK = 2'b01,
    LCD_OAM    = 2'b10,
    LCD_XFER   = 2'b11
  } lcd_mode_e;

  typedef struct packed {
    logic hs;
    logic vs;
    logic blank;
  } sync_t;

  localparam sync_t SYNC_IDLE = '{hs: 1'b0, vs: 1'b0, blank: 1'b1};

  // Active width plus horizontal blanking; blanking defaults match the
  // standard timing so h_total(NCH, XS) alone gives the stock line length.
  function automatic int h_total(int nch, int xs, int gb_w = GB_W,
                                 int hfp = 8, int hs = 32, int hbp = 24);
    return nch * gb_w * xs + hfp + hs + hbp;
  endfunction

endpackage

// File: rtl/lcd_chan_buf.sv
// lcd_chan_buf -- one input screen's frame buffer.
//   clk, reset_n : clock, async active-low reset
//   on           : LCD enable for this channel
//   clkena, data : pixel write strobe and pixel
//   mode         : LCD controller mode (VBLANK ends a frame)
//   rd_en        : read-port enable (output pixel-clock enable)
//   rd_addr      : read address
//   rd_data      : registered read data, valid one rd_en tick after rd_addr
//   frame_ok     : last frame delivered was complete
module lcd_chan_buf #(
  parameter int PW    = 15,
  parameter int DEPTH = 23040,
  localparam int AW   = $clog2(DEPTH + 1),
  localparam int MW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          on,
  input  logic          clkena,
  input  logic [PW-1:0] data,
  input  logic [1:0]    mode,
  input  logic          rd_en,
  input  logic [MW-1:0] rd_addr,
  output logic [PW-1:0] rd_data,
  output logic          frame_ok
);
  import lcd_mux_pkg::*;

  localparam logic [AW-1:0] FULL = AW'(DEPTH);

  logic [PW-1:0] mem [DEPTH];
  logic [AW-1:0] wptr;
  logic          wr_en;
  logic          in_vblank;
  logic          vblank_q;

  // Writes past a full frame are dropped so overlong lines cannot wrap
  // around and corrupt the top of the picture.
  assign wr_en     = clkena && (wptr < FULL);
  assign in_vblank = (mode == LCD_VBLANK);

  // NOTE: the frame store has no reset; its contents are never trusted until
  // frame_ok says a full frame has landed, and a resettable RAM cannot map
  // onto block memory.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr[MW-1:0]] <= data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples its inputs from before the edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr <= '0;
    end else if (!on || in_vblank) begin
      wptr <= '0;
    end else if (wr_en) begin
      wptr <= wptr + 1'b1;
    end
  end

  // A frame is judged on entry to vblank: wptr still holds the count of the
  // frame just finished, because its clear takes effect on the same edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vblank_q <= 1'b0;
      frame_ok <= 1'b0;
    end else begin
      vblank_q <= in_vblank;
      if (!on) begin
        frame_ok <= 1'b0;
      end else if (in_vblank && !vblank_q) begin
        frame_ok <= (wptr == FULL);
      end
    end
  end

endmodule

// File: rtl/lcd_mux_scanout.sv
// lcd_mux_scanout -- buffers NCH LCD pixel streams and replays them through
// one programmable video timing generator, tiled side by side or as a single
// selected screen, with horizontal replication.
//   clk, reset_n  : clock, async active-low reset
//   pce           : output pixel-clock enable (read side advances on it)
//   clkena, data  : per-channel pixel write strobe and pixel (ch k at k*PW)
//   mode, on      : per-channel LCD mode (2 bits each) and LCD enable
//   tile, sel     : layout select, latched at vsync start
//   hs, vs, blank : positive syncs and blanking, aligned with pix
//   pix           : output pixel, 0 when black
//   frame_ok      : per-channel complete-frame flags
module lcd_mux_scanout #(
  parameter int NCH   = 2,
  parameter int PW    = 15,
  parameter int GB_W  = 160,
  parameter int GB_H  = 144,
  parameter int XS    = 2,
  parameter int HFP   = 8,
  parameter int HS    = 32,
  parameter int HBP   = 24,
  parameter int VPRE  = 48,
  parameter int VPOST = 48,
  parameter int VFP   = 4,
  parameter int VS    = 3,
  parameter int VBP   = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              pce,
  input  logic [NCH-1:0]    clkena,
  input  logic [NCH*PW-1:0] data,
  input  logic [2*NCH-1:0]  mode,
  input  logic [NCH-1:0]    on,
  input  logic              tile,
  input  logic [1:0]        sel,
  output logic              hs,
  output logic              vs,
  output logic              blank,
  output logic [PW-1:0]     pix,
  output logic [NCH-1:0]    frame_ok
);
  import lcd_mux_pkg::*;

  localparam int H_ACT    = NCH * GB_W * XS;
  localparam int H_TOTAL  = h_total(NCH, XS, GB_W, HFP, HS, HBP);
  localparam int V_IMG1   = VPRE + GB_H;
  localparam int V_ACT    = V_IMG1 + VPOST;
  localparam int V_VS0    = V_ACT + VFP;
  localparam int V_VS1    = V_VS0 + VS;
  localparam int V_TOTAL  = V_VS1 + VBP;
  localparam int FRAME_SZ = GB_W * GB_H;

  // Counter widths carry one spare bit so every boundary constant fits.
  localparam int HW = $clog2(H_TOTAL + 1);
  localparam int VW = $clog2(V_TOTAL + 1);
  localparam int AW = $clog2(FRAME_SZ + 1);
  localparam int MW = (FRAME_SZ > 1) ? $clog2(FRAME_SZ) : 1;
  localparam int CW = (GB_W > 1) ? $clog2(GB_W) : 1;
  localparam int RW = $clog2(NCH * XS + 1);

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT_C  = HW'(H_ACT);
  localparam logic [HW-1:0] H_HS0    = HW'(H_ACT + HFP);
  localparam logic [HW-1:0] H_HS1    = HW'(H_ACT + HFP + HS);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_IMG0_C = VW'(VPRE);
  localparam logic [VW-1:0] V_IMG1_C = VW'(V_IMG1);
  localparam logic [VW-1:0] V_ACT_C  = VW'(V_ACT);
  localparam logic [VW-1:0] V_VS0_C  = VW'(V_VS0);
  localparam logic [VW-1:0] V_VS1_C  = VW'(V_VS1);
  localparam logic [VW-1:0] V_SAMPLE = VW'(V_VS0 - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(GB_W - 1);
  localparam logic [RW-1:0] REP_TILE = RW'(XS - 1);
  localparam logic [RW-1:0] REP_ONE  = RW'(NCH * XS - 1);
  localparam logic [AW-1:0] LINE_INC = AW'(GB_W);

  // ---------------------------------------------------------------- buffers
  logic [PW-1:0] rd_data [NCH];
  logic [MW-1:0] rd_addr;

  for (genvar k = 0; k < NCH; k++) begin : g_chan
    lcd_chan_buf #(
      .PW    (PW),
      .DEPTH (FRAME_SZ)
    ) u_buf (
      .clk      (clk),
      .reset_n  (reset_n),
      .on       (on[k]),
      .clkena   (clkena[k]),
      .data     (data[k*PW +: PW]),
      .mode     (mode[2*k +: 2]),
      .rd_en    (pce),
      .rd_addr  (rd_addr),
      .rd_data  (rd_data[k]),
      .frame_ok (frame_ok[k])
    );
  end

  // ----------------------------------------------------- timing and address
  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic [RW-1:0] rep_cnt;   // replication phase within one source pixel
  logic [CW-1:0] col_cnt;   // source column
  logic [2:0]    chan_cnt;  // tile index, advances each time a line of columns ends
  logic [AW-1:0] line_base; // first buffer address of the current image line
  logic          tile_q;
  logic [1:0]    sel_q;

  logic          h_last;
  logic          img_line;
  logic [RW-1:0] rep_max;

  assign h_last   = (h_cnt == H_LAST);
  assign img_line = (v_cnt >= V_IMG0_C) && (v_cnt < V_IMG1_C);
  // Tiled: XS ticks per source pixel. Single: the one screen is stretched
  // across the whole active width, so NCH*XS ticks per source pixel.
  assign rep_max  = tile_q ? REP_TILE : REP_ONE;
  assign rd_addr  = MW'(line_base + AW'(col_cnt));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h_cnt     <= '0;
      v_cnt     <= '0;
      rep_cnt   <= '0;
      col_cnt   <= '0;
      chan_cnt  <= '0;
      line_base <= '0;
      tile_q    <= 1'b1;
      sel_q     <= '0;
    end else if (pce) begin
      if (h_last) begin
        h_cnt    <= '0;
        rep_cnt  <= '0;
        col_cnt  <= '0;
        chan_cnt <= '0;
        v_cnt    <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
        // Row base steps by one line per image line and parks at 0 outside
        // the image, so the first image line always starts at address 0.
        line_base <= img_line ? line_base + LINE_INC : '0;
        // Layout only changes as vsync begins, never inside a visible frame.
        if (v_cnt == V_SAMPLE) begin
          tile_q <= tile;
          sel_q  <= sel;
        end
      end else begin
        h_cnt <= h_cnt + 1'b1;
        if (rep_cnt == rep_max) begin
          rep_cnt <= '0;
          if (col_cnt == COL_LAST) begin
            col_cnt  <= '0;
            chan_cnt <= chan_cnt + 1'b1;
          end else begin
            col_cnt <= col_cnt + 1'b1;
          end
        end else begin
          rep_cnt <= rep_cnt + 1'b1;
        end
      end
    end
  end

  // --------------------------------------------------------- stage 0 decode
  logic [2:0] cur_chan;
  logic       chan_ok;
  logic       vis0;
  sync_t      sync0;

  assign cur_chan = tile_q ? chan_cnt : {1'b0, sel_q};

  // NOTE: every signal written in always_comb gets a default first so no
  // path through the block can leave it holding its old value (a latch).
  // A channel index with no matching buffer (sel >= NCH) falls through to 0.
  always_comb begin
    chan_ok = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      if (cur_chan == 3'(k)) chan_ok = on[k] && frame_ok[k];
    end
  end

  assign vis0        = (h_cnt < H_ACT_C) && img_line && chan_ok;
  assign sync0.hs    = (h_cnt >= H_HS0) && (h_cnt < H_HS1);
  assign sync0.vs    = (v_cnt >= V_VS0_C) && (v_cnt < V_VS1_C);
  assign sync0.blank = (h_cnt >= H_ACT_C) || (v_cnt >= V_ACT_C);

  // ------------------------------------------- stage 1 (RAM read) / stage 2
  sync_t         sync1;
  logic          vis1;
  logic [2:0]    chan1;
  logic [PW-1:0] rd_mux;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= SYNC_IDLE;
      vis1  <= 1'b0;
      chan1 <= '0;
    end else if (pce) begin
      sync1 <= sync0;
      vis1  <= vis0;
      chan1 <= cur_chan;
    end
  end

  always_comb begin
    rd_mux = '0;
    for (int k = 0; k < NCH; k++) begin
      if (chan1 == 3'(k)) rd_mux = rd_data[k];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hs    <= SYNC_IDLE.hs;
      vs    <= SYNC_IDLE.vs;
      blank <= SYNC_IDLE.blank;
      pix   <= '0;
    end else if (pce) begin
      hs    <= sync1.hs;
      vs    <= sync1.vs;
      blank <= sync1.blank;
      pix   <= vis1 ? rd_mux : '0;
    end
  end

endmodule

// File: tb/tb_lcd_mux_scanout.sv
// tb_lcd_mux_scanout -- directed bench for lcd_mux_scanout on a shrunken
// geometry (8x4 screens, 40x11 output raster) so whole frames run quickly.
module tb_lcd_mux_scanout;

  localparam int NCH = 2, PW = 15, GB_W = 8, GB_H = 4, XS = 2;
  localparam int HFP = 2, HS = 3, HBP = 3;
  localparam int VPRE = 2, VPOST = 2, VFP = 1, VS = 1, VBP = 1;
  localparam int H_ACT = NCH * GB_W * XS;                      // 32
  localparam int HT    = H_ACT + HFP + HS + HBP;                // 40
  localparam int VT    = VPRE + GB_H + VPOST + VFP + VS + VBP;  // 11
  localparam int FRAME = GB_W * GB_H;                           // 32

  logic              clk = 1'b0;
  logic              reset_n, pce, tile;
  logic [NCH-1:0]    clkena, on;
  logic [NCH*PW-1:0] data;
  logic [2*NCH-1:0]  mode;
  logic [1:0]        sel;
  logic              hs, vs, blank;
  logic [PW-1:0]     pix;
  logic [NCH-1:0]    frame_ok;

  int n_assert = 0;
  int n_fail   = 0;
  int ticks;  // pce edges since reset release; output shows raster position ticks-2

  lcd_mux_scanout #(
    .NCH(NCH), .PW(PW), .GB_W(GB_W), .GB_H(GB_H), .XS(XS),
    .HFP(HFP), .HS(HS), .HBP(HBP),
    .VPRE(VPRE), .VPOST(VPOST), .VFP(VFP), .VS(VS), .VBP(VBP)
  ) dut (
    .clk(clk), .reset_n(reset_n), .pce(pce), .clkena(clkena), .data(data),
    .mode(mode), .on(on), .tile(tile), .sel(sel),
    .hs(hs), .vs(vs), .blank(blank), .pix(pix), .frame_ok(frame_ok)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) ticks <= 0;
    else if (pce) ticks <= ticks + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance (at least 3 cycles) to the next negedge where pix shows (v,h).
  task automatic wait_pos(input int v, input int h);
    bit found = 1'b0;
    int p;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2 * HT * VT + 8; i++) begin
      if (ticks >= 2) begin
        p = ticks - 2;
        if ((p % HT) == h && ((p / HT) % VT) == v) begin
          found = 1'b1;
          break;
        end
      end
      @(negedge clk);
    end
    n_assert++;
    assert (found) else begin
      n_fail++;
      $error("FAIL wait_v%0d_h%0d: observed timeout expected position", v, h);
    end
  endtask

  // Wait for the tick just before hs should rise after a reset release.
  task automatic wait_hs_edge();
    for (int i = 0; i < 200 && ticks != H_ACT + HFP + 1; i++) @(negedge clk);
  endtask

  task automatic write_px(input logic [1:0] ch, input int n,
                          input logic [14:0] b0, input logic [14:0] b1);
    for (int i = 0; i < n; i++) begin
      clkena = ch;
      data   = {15'(b1 + i), 15'(b0 + i)};
      @(negedge clk);
    end
    clkena = '0;
  endtask

  initial begin
    reset_n = 1'b0; pce = 1'b1; clkena = '0; data = '0;
    mode = '0; on = '0; tile = 1'b1; sel = 2'd0;
    repeat (3) @(negedge clk);
    check("rst_hs", hs, 0);
    check("rst_vs", vs, 0);
    check("rst_blank", blank, 1);
    check("rst_pix", pix, 0);
    check("rst_frame_ok", frame_ok, 0);
    reset_n = 1'b1;

    // Sync timing from a clean start
    wait_hs_edge();
    check("hs_pre_edge", hs, 0);
    @(negedge clk);
    check("hs_rise", hs, 1);
    check("hs_rise_blank", blank, 1);
    wait_pos(8, 39);
    check("vs_before", vs, 0);
    @(negedge clk);
    check("vs_start", vs, 1);
    check("vs_blank", blank, 1);
    wait_pos(VPRE, 0);
    check("no_frame_black", pix, 0);
    check("no_frame_unblank", blank, 0);

    // Full frames on both channels: ch0 = 0x0100+i, ch1 = 0x7C00+i
    on = 2'b11; mode = 4'b1111;
    write_px(2'b11, FRAME, 15'h0100, 15'h7C00);
    mode = 4'b0101;
    repeat (2) @(negedge clk);
    check("full_frame_ok", frame_ok, 2'b11);
    wait_pos(VPRE - 1, 0);
    check("pre_lines_black", pix, 0);
    check("pre_lines_unblank", blank, 0);
    wait_pos(VPRE, 0);
    check("tile_l0_h0", pix, 15'h0100);
    wait_pos(VPRE + 1, 5);
    check("tile_l1_h5", pix, 15'h010A);
    wait_pos(VPRE + 1, 15);
    check("tile_l1_h15", pix, 15'h010F);
    wait_pos(VPRE + 1, 16);
    check("tile_l1_h16", pix, 15'h7C08);
    wait_pos(VPRE + 3, 31);
    check("tile_l3_h31", pix, 15'h7C1F);
    wait_pos(VPRE + 3, 32);
    check("hblank_pix", pix, 0);
    check("hblank_blank", blank, 1);
    wait_pos(VPRE + GB_H, 0);
    check("post_lines_black", pix, 0);
    wait_pos(VPRE + 2, 5);
    check("hold_start", pix, 15'h0112);
    pce = 1'b0;
    repeat (3) @(negedge clk);
    check("pce_hold", pix, 15'h0112);
    pce = 1'b1;

    // Short frame on ch1: one pixel missing
    mode = 4'b1101;
    write_px(2'b10, FRAME - 1, 15'h0000, 15'h5000);
    mode = 4'b0101;
    repeat (2) @(negedge clk);
    check("short_frame_ok", frame_ok, 2'b01);
    wait_pos(VPRE, 16);
    check("short_ch1_black", pix, 0);
    wait_pos(VPRE + 1, 2);
    check("short_ch0_intact", pix, 15'h0109);

    // Overlong frame on ch1: extra pixels must not wrap to address 0
    mode = 4'b1101;
    write_px(2'b10, FRAME + 5, 15'h0000, 15'h2000);
    mode = 4'b0101;
    repeat (2) @(negedge clk);
    check("long_frame_ok", frame_ok, 2'b11);
    wait_pos(VPRE, 16);
    check("long_addr0", pix, 15'h2000);
    wait_pos(VPRE + 3, 31);
    check("long_addr31", pix, 15'h201F);

    // Single-screen ch1, requested mid-frame
    wait_pos(VPRE + 1, 0);
    check("pre_switch", pix, 15'h0108);
    tile = 1'b0; sel = 2'd1;
    wait_pos(VPRE + 2, 16);
    check("no_tearing", pix, 15'h2010);
    wait_pos(VPRE, 0);
    check("single_h0", pix, 15'h2000);
    wait_pos(VPRE, 3);
    check("single_h3", pix, 15'h2000);
    @(negedge clk);
    check("single_h4", pix, 15'h2001);
    wait_pos(VPRE + 3, 20);
    check("single_l3_h20", pix, 15'h201D);
    wait_pos(VPRE + 3, 31);
    check("single_l3_h31", pix, 15'h201F);

    // Selecting a channel that does not exist
    sel = 2'd3;
    wait_pos(VPRE, 0);
    check("sel3_black", pix, 0);
    check("sel3_unblank", blank, 0);
    wait_pos(VPRE + 2, 20);
    check("sel3_black_mid", pix, 0);

    // Back to tiled, then drop ch0 mid-line
    tile = 1'b1; sel = 2'd0;
    wait_pos(VPRE + 1, 2);
    check("retile_h2", pix, 15'h0109);
    on = 2'b10;
    @(negedge clk);
    check("off_in_flight", pix, 15'h0109);
    check("off_frame_ok", frame_ok, 2'b10);
    @(negedge clk);
    check("off_black", pix, 0);
    wait_pos(VPRE + 1, 16);
    check("off_ch1_intact", pix, 15'h2008);

    // Reset pulse mid-frame on a visible pixel
    wait_pos(VPRE + 2, 17);
    check("pre_reset_pix", pix, 15'h2010);
    reset_n = 1'b0;
    #1;
    check("mid_rst_blank", blank, 1);
    check("mid_rst_pix", pix, 0);
    check("mid_rst_hs", hs, 0);
    check("mid_rst_vs", vs, 0);
    check("mid_rst_frame_ok", frame_ok, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    wait_hs_edge();
    check("rst_hs_pre_edge", hs, 0);
    @(negedge clk);
    check("rst_hs_rise", hs, 1);
    wait_pos(VPRE, 16);
    check("post_rst_black", pix, 0);

    // A fresh complete frame brings ch1 back
    mode = 4'b1101;
    write_px(2'b10, FRAME, 15'h0000, 15'h3000);
    mode = 4'b0101;
    repeat (2) @(negedge clk);
    check("refill_frame_ok", frame_ok, 2'b10);
    wait_pos(VPRE, 17);
    check("refill_ch1", pix, 15'h3000);
    wait_pos(VPRE + 1, 0);
    check("refill_ch0_off", pix, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
